// File: rtl/reaction_arbiter.sv
// reaction_arbiter: start countdown, then latch the first eligible press.
// False-start disqualification, rotating tie-break, timeout, saturating scores.
module reaction_arbiter #(
  parameter int NUM_PLAYERS   = 4,
  parameter int TICK_CYCLES   = 50_000_000,
  parameter int COUNT_START   = 5,
  parameter int TIMEOUT_TICKS = 10,
  parameter int HOLD_TICKS    = 3,
  parameter int FALSE_START   = 1,
  parameter int SCORE_W       = 4,
  localparam int IDW = $clog2(NUM_PLAYERS)
)(
  input  logic                           CLOCK_50,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           clear_scores,
  input  logic [NUM_PLAYERS-1:0]         btn_n,
  output logic [3:0]                     count_digit,
  output logic                           armed,
  output logic                           winner_valid,
  output logic [IDW-1:0]                 winner_id,
  output logic [NUM_PLAYERS-1:0]         winner_onehot,
  output logic [NUM_PLAYERS-1:0]         disq,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores
);

  localparam int N    = NUM_PLAYERS;
  localparam int TW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int PMAX = (TIMEOUT_TICKS > HOLD_TICKS) ? TIMEOUT_TICKS
                                                     : HOLD_TICKS;
  localparam int PW   = $clog2(PMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_ARMED,
    S_RESULT
  } state_t;

  state_t             r_state, w_state_n;
  logic [N-1:0]       r_s1, r_s2, r_prev;
  logic [TW-1:0]      r_tcnt;
  logic [PW-1:0]      r_pcnt, w_pcnt_n;
  logic [3:0]         r_digit, w_digit_n;
  logic               r_armed;
  logic               r_win_v, w_win_v_n;
  logic [IDW-1:0]     r_win_id, w_win_id_n;
  logic [N-1:0]       r_win_oh, w_win_oh_n;
  logic [N-1:0]       r_disq, w_disq_n;
  logic [N*SCORE_W-1:0] r_scores, w_scores_n;
  logic [IDW-1:0]     r_ptr, w_ptr_n;

  logic [N-1:0]       w_press, w_elig, w_oh;
  logic               w_tick, w_found;
  logic [IDW-1:0]     w_win, w_idx;
  int                 w_s;

  // Press event is a falling edge of the synchronised button.
  assign w_press = r_prev & ~r_s2;
  assign w_elig  = w_press & ~r_disq;
  assign w_tick  = (r_tcnt == TW'(TICK_CYCLES - 1));

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    w_s     = 0;
    w_oh    = '0;
    // Scan downward so the candidate nearest the pointer is taken last.
    for (int k = N - 1; k >= 0; k--) begin
      w_s = int'(r_ptr) + k;
      if (w_s >= N) w_s = w_s - N;
      w_idx = IDW'(w_s);
      if (w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    for (int i = 0; i < N; i++)
      w_oh[i] = w_found && (w_win == IDW'(i));
  end

  always_comb begin
    w_state_n  = r_state;
    w_pcnt_n   = r_pcnt;
    w_digit_n  = r_digit;
    w_win_v_n  = r_win_v;
    w_win_id_n = r_win_id;
    w_win_oh_n = r_win_oh;
    w_disq_n   = r_disq;
    w_scores_n = r_scores;
    w_ptr_n    = r_ptr;
    unique case (r_state)
      S_IDLE: begin
        if (clear_scores) w_scores_n = '0;
        if (start) begin
          w_state_n  = S_COUNT;
          w_digit_n  = 4'(COUNT_START);
          w_disq_n   = '0;
          w_win_v_n  = 1'b0;
          w_win_id_n = '0;
          w_win_oh_n = '0;
        end
      end
      S_COUNT: begin
        if (FALSE_START != 0) w_disq_n = r_disq | w_press;
        if (&w_disq_n) begin
          w_state_n = S_RESULT;
          w_digit_n = '0;
        end else if (w_tick) begin
          if (r_digit <= 4'd1) begin
            w_digit_n = '0;
            w_state_n = S_ARMED;
          end else begin
            w_digit_n = r_digit - 4'd1;
          end
        end
      end
      S_ARMED: begin
        if (w_found) begin
          w_state_n  = S_RESULT;
          w_win_v_n  = 1'b1;
          w_win_id_n = w_win;
          w_win_oh_n = w_oh;
          w_ptr_n    = (w_win == IDW'(N - 1)) ? '0 : w_win + 1'b1;
          for (int i = 0; i < N; i++)
            if (w_oh[i] && (r_scores[i*SCORE_W +: SCORE_W] != '1))
              w_scores_n[i*SCORE_W +: SCORE_W] =
                r_scores[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
        end else if (w_tick) begin
          if (r_pcnt == PW'(TIMEOUT_TICKS - 1))
            w_state_n = S_RESULT;
          else
            w_pcnt_n = r_pcnt + 1'b1;
        end
      end
      S_RESULT: begin
        if (w_tick) begin
          if (r_pcnt == PW'(HOLD_TICKS - 1)) begin
            w_state_n  = S_IDLE;
            w_win_v_n  = 1'b0;
            w_win_id_n = '0;
            w_win_oh_n = '0;
          end else begin
            w_pcnt_n = r_pcnt + 1'b1;
          end
        end
      end
    endcase
    if (w_state_n != r_state) w_pcnt_n = '0;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_s1     <= '1;
      r_s2     <= '1;
      r_prev   <= '1;
      r_state  <= S_IDLE;
      r_tcnt   <= '0;
      r_pcnt   <= '0;
      r_digit  <= '0;
      r_armed  <= 1'b0;
      r_win_v  <= 1'b0;
      r_win_id <= '0;
      r_win_oh <= '0;
      r_disq   <= '0;
      r_scores <= '0;
      r_ptr    <= '0;
    end else begin
      r_s1     <= btn_n;
      r_s2     <= r_s1;
      r_prev   <= r_s2;
      r_state  <= w_state_n;
      r_tcnt   <= ((w_state_n != r_state) || w_tick) ? '0
                                                     : r_tcnt + 1'b1;
      r_pcnt   <= w_pcnt_n;
      r_digit  <= w_digit_n;
      r_armed  <= (w_state_n == S_ARMED);
      r_win_v  <= w_win_v_n;
      r_win_id <= w_win_id_n;
      r_win_oh <= w_win_oh_n;
      r_disq   <= w_disq_n;
      r_scores <= w_scores_n;
      r_ptr    <= w_ptr_n;
    end
  end

  assign count_digit   = r_digit;
  assign armed         = r_armed;
  assign winner_valid  = r_win_v;
  assign winner_id     = r_win_id;
  assign winner_onehot = r_win_oh;
  assign disq          = r_disq;
  assign scores        = r_scores;

endmodule

// File: tb/tb_reaction_arbiter.sv
// tb_reaction_arbiter: table of game rounds with hand-computed results,
// plus reset-abort and clear_scores sequences.
module tb_reaction_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       clear_scores;
  logic [3:0] btn_n;
  logic [3:0] count_digit;
  logic       armed;
  logic       winner_valid;
  logic [1:0] winner_id;
  logic [3:0] winner_onehot;
  logic [3:0] disq;
  logic [7:0] scores;

  int n_cmp = 0;
  int n_err = 0;

  reaction_arbiter #(
    .NUM_PLAYERS(4),
    .TICK_CYCLES(10),
    .COUNT_START(3),
    .TIMEOUT_TICKS(4),
    .HOLD_TICKS(2),
    .FALSE_START(1),
    .SCORE_W(2)
  ) dut (
    .CLOCK_50(clk),
    .reset_n(reset_n),
    .start(start),
    .clear_scores(clear_scores),
    .btn_n(btn_n),
    .count_digit(count_digit),
    .armed(armed),
    .winner_valid(winner_valid),
    .winner_id(winner_id),
    .winner_onehot(winner_onehot),
    .disq(disq),
    .scores(scores)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] fs;
    logic [3:0] ap;
    logic       ev;
    logic [1:0] eid;
    logic [3:0] edq;
    logic [7:0] esc;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_round(input vec_t v);
    int c;
    int a;
    logic [3:0] eoh;
    eoh = v.ev ? (4'b0001 << v.eid) : 4'b0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (v.fs == 4'hF) begin
      for (c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (c == 3) btn_n = ~v.fs;
        if (c == 6) btn_n = 4'hF;
        if (c == 35) begin
          chk("allfs_armed", armed, 0);
          chk("allfs_valid", winner_valid, 0);
          chk("allfs_disq", disq, v.edq);
        end
      end
    end else begin
      c = 0;
      chk("digit_start", count_digit, 3);
      while (!armed && c < 45) begin
        @(negedge clk);
        c++;
        if (c == 3) btn_n = ~v.fs;
        if (c == 6) btn_n = 4'hF;
        if (c == 9) chk("digit_c9", count_digit, 3);
        if (c == 10) chk("digit_c10", count_digit, 2);
        if (c == 20) chk("digit_c20", count_digit, 1);
      end
      chk("arm_latency", c, 30);
      chk("arm_digit", count_digit, 0);
      a = 0;
      while (armed && a < 50) begin
        @(negedge clk);
        a++;
        if (a == 5) btn_n = ~v.ap;
        if (a == 8) btn_n = 4'hF;
      end
      btn_n = 4'hF;
      chk("armed_len", a, (v.ap != 0) ? 8 : 40);
      chk("win_valid", winner_valid, v.ev);
      chk("win_id", winner_id, v.eid);
      chk("win_onehot", winner_onehot, eoh);
      chk("disq", disq, v.edq);
      chk("scores", scores, v.esc);
      for (int h = 1; h <= 20; h++) begin
        @(negedge clk);
        if (h == 19) chk("hold_valid", winner_valid, v.ev);
        if (h == 20) begin
          chk("idle_valid", winner_valid, 0);
          chk("idle_onehot", winner_onehot, 0);
          chk("idle_disq", disq, v.edq);
        end
      end
    end
    btn_n = 4'hF;
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{4'h0, 4'h4, 1'b1, 2'd2, 4'h0, 8'h10};
    tbl[1]  = '{4'h2, 4'hA, 1'b1, 2'd3, 4'h2, 8'h50};
    tbl[2]  = '{4'h0, 4'h1, 1'b1, 2'd0, 4'h0, 8'h51};
    tbl[3]  = '{4'h0, 4'h3, 1'b1, 2'd1, 4'h0, 8'h55};
    tbl[4]  = '{4'h0, 4'h3, 1'b1, 2'd0, 4'h0, 8'h56};
    tbl[5]  = '{4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 8'h56};
    tbl[6]  = '{4'hF, 4'h0, 1'b0, 2'd0, 4'hF, 8'h56};
    tbl[7]  = '{4'h0, 4'h1, 1'b1, 2'd0, 4'h0, 8'h57};
    tbl[8]  = '{4'h0, 4'h1, 1'b1, 2'd0, 4'h0, 8'h57};
    tbl[9]  = '{4'h0, 4'h1, 1'b1, 2'd0, 4'h0, 8'h57};
    tbl[10] = '{4'h1, 4'h3, 1'b1, 2'd1, 4'h1, 8'h5B};

    reset_n      = 1'b0;
    start        = 1'b0;
    clear_scores = 1'b0;
    btn_n        = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_digit", count_digit, 0);
    chk("rst_armed", armed, 0);
    chk("rst_valid", winner_valid, 0);
    chk("rst_id", winner_id, 0);
    chk("rst_onehot", winner_onehot, 0);
    chk("rst_disq", disq, 0);
    chk("rst_scores", scores, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) run_round(tbl[i]);

    // Asynchronous reset in the middle of a countdown.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_rst_digit", count_digit, 2);
    reset_n = 1'b0;
    #1;
    chk("arst_digit", count_digit, 0);
    chk("arst_armed", armed, 0);
    chk("arst_valid", winner_valid, 0);
    chk("arst_disq", disq, 0);
    chk("arst_scores", scores, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (35) @(negedge clk);
    chk("abort_armed", armed, 0);
    chk("abort_digit", count_digit, 0);

    v = '{4'h0, 4'h4, 1'b1, 2'd2, 4'h0, 8'h10};
    run_round(v);
    v = '{4'h0, 4'h8, 1'b1, 2'd3, 4'h0, 8'h50};
    run_round(v);

    clear_scores = 1'b1;
    @(negedge clk);
    clear_scores = 1'b0;
    chk("clr_scores", scores, 0);
    chk("clr_digit", count_digit, 0);

    v = '{4'h0, 4'h1, 1'b1, 2'd0, 4'h0, 8'h01};
    run_round(v);
    clear_scores = 1'b1;
    start        = 1'b1;
    @(negedge clk);
    clear_scores = 1'b0;
    start        = 1'b0;
    chk("clrstart_scores", scores, 0);
    chk("clrstart_digit", count_digit, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
